// File: rtl/fetch_control.sv
// IF-stage sequencer: run control (IDLE/RUN/STEP/DRAIN/HALTED), redirect arbitration,
// PC / IF-ID enables and an active-cycle counter that saturates.
module fetch_control #(
  parameter int unsigned     NB           = 32,
  parameter logic [NB-1:0]   HALT_WORD    = {NB{1'b1}},
  parameter int unsigned     DRAIN_CYCLES = 4,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_start,
  input  logic             in_step,
  input  logic             in_stall,
  input  logic             in_ctl_branch,
  input  logic             in_ctl_jump_reg,
  input  logic             in_ctl_jump,
  input  logic [NB-1:0]    in_instruction,
  output logic             out_pc_write,
  output logic [1:0]       out_pc_sel,
  output logic             out_if_id_write,
  output logic             out_if_id_flush,
  output logic             out_pipe_enable,
  output logic             out_halted,
  output logic [2:0]       out_state,
  output logic [CNT_W-1:0] out_cycle_count
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t           state;
  logic [DW-1:0]    drain_cnt;
  logic [CNT_W-1:0] cycle_count;
  logic             redirect;
  logic             halt_fetch;

  assign redirect = in_ctl_branch | in_ctl_jump_reg | in_ctl_jump;

  always_comb begin
    out_pc_write    = 1'b0;
    out_pc_sel      = 2'b00;
    out_if_id_write = 1'b0;
    out_if_id_flush = 1'b0;
    out_pipe_enable = 1'b0;
    halt_fetch      = 1'b0;
    case (state)
      RUN, STEP: begin
        out_pipe_enable = 1'b1;
        // Redirect outranks HALT (wrong-path word) and stall.
        if (redirect) begin
          out_pc_write    = 1'b1;
          out_if_id_write = 1'b1;
          out_if_id_flush = 1'b1;
          if (in_ctl_branch)        out_pc_sel = 2'b01;
          else if (in_ctl_jump_reg) out_pc_sel = 2'b11;
          else                      out_pc_sel = 2'b10;
        end else if (in_instruction == HALT_WORD) begin
          out_if_id_write = 1'b1;
          out_if_id_flush = 1'b1;
          halt_fetch      = 1'b1;
        end else if (!in_stall) begin
          out_pc_write    = 1'b1;
          out_if_id_write = 1'b1;
        end
      end
      DRAIN: begin
        out_if_id_write = 1'b1;
        out_if_id_flush = 1'b1;
        out_pipe_enable = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      cycle_count <= '0;
    end else begin
      if (out_pipe_enable && (cycle_count != '1))
        cycle_count <= cycle_count + CNT_W'(1);
      case (state)
        IDLE: begin
          if (in_start)     state <= RUN;
          else if (in_step) state <= STEP;
        end
        RUN: begin
          if (halt_fetch) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        STEP: begin
          if (halt_fetch) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state     <= HALTED;
          else                 drain_cnt <= drain_cnt - DW'(1);
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  assign out_halted      = (state == HALTED);
  assign out_state       = state;
  assign out_cycle_count = cycle_count;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control: run control, redirect priority, halt/drain, step and reset.
module tb_fetch_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_start, in_step, in_stall;
  logic        in_ctl_branch, in_ctl_jump_reg, in_ctl_jump;
  logic [31:0] in_instruction;
  logic        out_pc_write, out_if_id_write, out_if_id_flush, out_pipe_enable, out_halted;
  logic [1:0]  out_pc_sel;
  logic [2:0]  out_state;
  logic [31:0] out_cycle_count;

  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_pipe_enable, s_halted;
  logic [1:0]  s_pc_sel;
  logic [2:0]  s_state;
  logic [2:0]  s_cycle_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_control #(.NB(32), .HALT_WORD(32'hFFFFFFFF), .DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_start(in_start), .in_step(in_step), .in_stall(in_stall),
    .in_ctl_branch(in_ctl_branch), .in_ctl_jump_reg(in_ctl_jump_reg), .in_ctl_jump(in_ctl_jump),
    .in_instruction(in_instruction),
    .out_pc_write(out_pc_write), .out_pc_sel(out_pc_sel),
    .out_if_id_write(out_if_id_write), .out_if_id_flush(out_if_id_flush),
    .out_pipe_enable(out_pipe_enable), .out_halted(out_halted),
    .out_state(out_state), .out_cycle_count(out_cycle_count)
  );

  // Narrow counter copy to exercise saturation.
  fetch_control #(.NB(32), .HALT_WORD(32'hFFFFFFFF), .DRAIN_CYCLES(4), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset),
    .in_start(in_start), .in_step(in_step), .in_stall(in_stall),
    .in_ctl_branch(in_ctl_branch), .in_ctl_jump_reg(in_ctl_jump_reg), .in_ctl_jump(in_ctl_jump),
    .in_instruction(in_instruction),
    .out_pc_write(s_pc_write), .out_pc_sel(s_pc_sel),
    .out_if_id_write(s_if_id_write), .out_if_id_flush(s_if_id_flush),
    .out_pipe_enable(s_pipe_enable), .out_halted(s_halted),
    .out_state(s_state), .out_cycle_count(s_cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_ctl();
    in_ctl_branch = 1'b0; in_ctl_jump_reg = 1'b0; in_ctl_jump = 1'b0; in_stall = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    in_start = 1'b0; in_step = 1'b0; in_instruction = '0;
    clear_ctl();
    #2;
    check("rst_state", out_state, 0);
    check("rst_outputs", {out_pc_write, out_pc_sel, out_if_id_write, out_if_id_flush, out_pipe_enable, out_halted}, 0);
    tick(1);
    reset = 1'b1;

    // 1: idle without start
    tick(10);
    check("idle_state", out_state, 0);
    check("idle_pc_write", out_pc_write, 0);
    check("idle_pipe_en", out_pipe_enable, 0);
    check("idle_count", out_cycle_count, 0);

    // 2: start, five RUN cycles
    in_start = 1'b1;
    #1;
    check("idle_start_pc_write", out_pc_write, 0);
    tick(1);
    in_start = 1'b0;
    check("run_state", out_state, 1);
    check("run_count0", out_cycle_count, 0);
    tick(5);
    check("run_state5", out_state, 1);
    check("run_pc_write", out_pc_write, 1);
    check("run_pc_sel", out_pc_sel, 0);
    check("run_ifid", {out_if_id_write, out_if_id_flush, out_pipe_enable}, 3'b101);
    check("run_count5", out_cycle_count, 5);
    check("sat_count5", s_cycle_count, 5);

    // 3: redirect priority (combinational, same cycle)
    in_ctl_branch = 1'b1; in_ctl_jump = 1'b1;
    #1;
    check("br_jmp_sel", out_pc_sel, 2'b01);
    check("br_jmp_ctl", {out_pc_write, out_if_id_write, out_if_id_flush}, 3'b111);
    in_ctl_branch = 1'b0; in_ctl_jump_reg = 1'b1;
    #1;
    check("jr_jmp_sel", out_pc_sel, 2'b11);

    // 4: stall, then stall overridden by jump
    clear_ctl();
    in_stall = 1'b1;
    #1;
    check("stall_ctl", {out_pc_write, out_if_id_write, out_if_id_flush}, 3'b000);
    in_ctl_jump = 1'b1;
    #1;
    check("stall_jmp_ctl", {out_pc_write, out_if_id_write, out_if_id_flush}, 3'b111);
    check("stall_jmp_sel", out_pc_sel, 2'b10);

    // 5: HALT with branch is wrong-path
    clear_ctl();
    in_instruction = 32'hFFFFFFFF; in_ctl_branch = 1'b1;
    #1;
    check("halt_br_sel", {out_pc_write, out_pc_sel}, 3'b101);
    tick(1);
    check("halt_br_state", out_state, 1);
    check("halt_br_count", out_cycle_count, 6);

    // HALT proper
    in_ctl_branch = 1'b0;
    #1;
    check("halt_ctl", {out_pc_write, out_if_id_write, out_if_id_flush, out_pipe_enable}, 4'b0111);
    tick(1);
    in_instruction = '0; in_start = 1'b1; in_ctl_branch = 1'b1;
    #1;
    check("drain_state", out_state, 3);
    check("drain_ctl", {out_pc_write, out_if_id_write, out_if_id_flush, out_pipe_enable}, 4'b0111);
    tick(3);
    check("drain_state3", out_state, 3);
    tick(1);
    check("halted_state", out_state, 4);
    check("halted_flag", out_halted, 1);
    check("halted_pipe_en", out_pipe_enable, 0);
    check("halted_count", out_cycle_count, 11);
    check("sat_count", s_cycle_count, 7);
    in_step = 1'b1;
    tick(3);
    check("halted_hold", out_state, 4);
    check("halted_count_frozen", out_cycle_count, 11);
    in_start = 1'b0; in_step = 1'b0;
    clear_ctl();

    // 6: reset, single step
    reset = 1'b0;
    #1;
    check("rst_halted_state", out_state, 0);
    check("rst_halted_count", out_cycle_count, 0);
    reset = 1'b1;
    tick(1);
    in_step = 1'b1;
    #1;
    check("step_idle_pc_write", out_pc_write, 0);
    tick(1);
    in_step = 1'b0;
    check("step_state", out_state, 2);
    check("step_ctl", {out_pc_write, out_pipe_enable}, 2'b11);
    tick(1);
    check("step_back_idle", out_state, 0);
    check("step_count", out_cycle_count, 1);
    check("step_idle_pc", out_pc_write, 0);

    // Step fetching HALT goes to DRAIN; reset mid-drain is immediate
    in_step = 1'b1;
    tick(1);
    in_step = 1'b0; in_instruction = 32'hFFFFFFFF;
    tick(1);
    in_instruction = '0;
    check("step_halt_drain", out_state, 3);
    check("step_halt_count", out_cycle_count, 2);
    tick(1);
    reset = 1'b0;
    #1;
    check("rst_drain_state", out_state, 0);
    check("rst_drain_count", out_cycle_count, 0);
    tick(1);
    reset = 1'b1;

    // start and step together: start wins
    in_start = 1'b1; in_step = 1'b1;
    tick(1);
    in_start = 1'b0; in_step = 1'b0;
    check("start_wins", out_state, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
